// File: rtl/ysyx_22050612_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// the bubble instruction and the default boot address.
package ysyx_22050612_ifu_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3,
    S_ERR  = 3'd4
  } ifu_state_e;

  // addi x0, x0, 0 -- what decode sees before anything has been fetched
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ysyx_22050612_ifu_muxkey.sv
// Generic key/value lookup mux: the lut packs NR_KEY {key, data} pairs,
// pair 0 in the least significant bits. Unmatched keys yield zero.
module ysyx_22050612_MuxKey #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 32
) (
  output logic [DATA_LEN-1:0]                  out,
  input  logic [KEY_LEN-1:0]                   key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut
);

  localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

  // Scan every pair and forward the data of the one whose key matches
  always_comb begin
    out = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (lut[i*PAIR_LEN+DATA_LEN +: KEY_LEN] == key) begin
        out = lut[i*PAIR_LEN +: DATA_LEN];
      end
    end
  end

endmodule

// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch stage: owns the architectural PC, issues one outstanding
// doubleword fetch at a time, picks the 32-bit word addressed by pc[2] and
// hands it to decode. A redirect from EXU replaces the PC; a fetch already in
// flight when that happens is marked by kill and its response thrown away.
module ysyx_22050612_ifu
  import ysyx_22050612_ifu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [63:0]     imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_err
);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [31:0]     sel_word;
  logic            bad_target;

  // Upper word when pc[2] is set, lower word otherwise
  ysyx_22050612_MuxKey #(
    .NR_KEY  (2),
    .KEY_LEN (1),
    .DATA_LEN(32)
  ) u_word_sel (
    .out(sel_word),
    .key(pc_q[2]),
    .lut({1'b1, imem_resp_data[63:32], 1'b0, imem_resp_data[31:0]})
  );

  assign bad_target = redirect_valid && (redirect_pc[1:0] != 2'b00);

  // Next-state, next-PC and instruction-latch decisions
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (imem_req_ready) begin
            kill_d  = 1'b1;
            state_d = S_WAIT;
          end
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (imem_resp_valid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d    = sel_word;
            inst_pc_d = pc_q;
            state_d   = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = S_REQ;
        end
      end
      S_ERR: state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
    // A misaligned target is fatal no matter which state saw it
    if (bad_target && (state_q != S_ERR)) begin
      pc_d    = redirect_pc;
      state_d = S_ERR;
    end
  end

  // State, PC, kill flag and held instruction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      kill_q    <= 1'b0;
      inst_q    <= NOP_INST;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      kill_q    <= kill_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = {pc_q[XLEN-1:3], 3'b000};
  assign inst_valid     = (state_q == S_OUT);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign fetch_err      = (state_q == S_ERR);

  // Responses are only legal while a fetch is outstanding or after a fault
  assert property (@(posedge clk) disable iff (!rst_n)
    imem_resp_valid |-> ((state_q == S_WAIT) || (state_q == S_ERR)));

endmodule
